// File: rtl/pulse_to_level_tx.sv
// rtl/pulse_to_level_tx.sv - stretches event strobes into spaced levels for a slow receiver
// Optional 4-phase ack handshake: define PULSE_TO_LEVEL_TX_ACK_EN.
`timescale 1ns/1ps
module pulse_to_level_tx #(
  parameter int STRETCH = 4,
  parameter int GAP     = 4,
  parameter int PEND_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pulse_i,
  input  logic              clear_i,
  input  logic              ack_i,
  output logic              level_o,
  output logic              busy_o,
  output logic [PEND_W-1:0] pending_o,
  output logic              overflow_o
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [7:0]        STRETCH_LD = 8'(STRETCH - 1);
  localparam logic [7:0]        GAP_LD     = 8'(GAP - 1);
  localparam logic [PEND_W-1:0] PEND_MAX   = '1;
  localparam logic [PEND_W-1:0] PEND_ONE   = PEND_W'(1);

  state_t            state, state_nxt;
  logic [7:0]        cnt, cnt_nxt;
  logic [PEND_W-1:0] pend_nxt;
  logic              high_release, low_release;
  logic              end_high, end_low, take_pending, incr, ovf_set;

`ifdef PULSE_TO_LEVEL_TX_ACK_EN
  assign high_release = ack_i;
  assign low_release  = ~ack_i;
`else
  logic unused_ack;
  assign unused_ack   = ack_i;
  assign high_release = 1'b1;
  assign low_release  = 1'b1;
`endif

  always_comb begin
    end_high     = (state == HIGH) && (cnt == 8'd0) && high_release;
    end_low      = (state == LOW) && (cnt == 8'd0) && low_release;
    take_pending = end_low && (pending_o != '0);
    // a pulse landing on the last LOW cycle with nothing queued is launched directly
    incr         = pulse_i && (state != IDLE) && !(end_low && (pending_o == '0));
    ovf_set      = incr && (pending_o == PEND_MAX) && !take_pending;

    pend_nxt = pending_o;
    if (incr && !ovf_set) pend_nxt = pend_nxt + PEND_ONE;
    if (take_pending)     pend_nxt = pend_nxt - PEND_ONE;

    state_nxt = state;
    cnt_nxt   = (cnt == 8'd0) ? cnt : cnt - 8'd1;
    case (state)
      IDLE: begin
        if (pulse_i) begin
          state_nxt = HIGH;
          cnt_nxt   = STRETCH_LD;
        end
      end
      HIGH: begin
        if (end_high) begin
          state_nxt = LOW;
          cnt_nxt   = GAP_LD;
        end
      end
      LOW: begin
        if (end_low) begin
          if (take_pending || pulse_i) begin
            state_nxt = HIGH;
            cnt_nxt   = STRETCH_LD;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = 8'd0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      level_o    <= 1'b0;
      busy_o     <= 1'b0;
      pending_o  <= '0;
      overflow_o <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      level_o    <= (state_nxt == HIGH);
      busy_o     <= (state_nxt != IDLE);
      pending_o  <= pend_nxt;
      overflow_o <= ovf_set | (overflow_o & ~clear_i);
    end
  end
endmodule

// File: tb/tb_pulse_to_level_tx.sv
// tb/tb_pulse_to_level_tx.sv - randomized and directed bench for pulse_to_level_tx
`timescale 1ns/1ps
module tb_pulse_to_level_tx;
  localparam int S = 4, G = 4, PW = 4, PMAX = 15;

  logic clk = 1'b0;
  logic reset = 1'b1, pulse_i = 1'b0, clear_i = 1'b0, ack_i = 1'b0;
  logic level_o, busy_o, overflow_o;
  logic [PW-1:0] pending_o;

  always #5 clk = ~clk;

  pulse_to_level_tx #(.STRETCH(S), .GAP(G), .PEND_W(PW)) dut (
    .clk(clk), .reset(reset), .pulse_i(pulse_i), .clear_i(clear_i), .ack_i(ack_i),
    .level_o(level_o), .busy_o(busy_o), .pending_o(pending_o), .overflow_o(overflow_o)
  );

  int total = 0, bad = 0;
  // timestamp model: an emission window opened at m_ws covers [m_ws, m_ws+S+G)
  int tnow = 0, m_pend = 0, m_ws = -1000;
  bit m_ovf = 1'b0;
  int accepted = 0, rises = 0;
  logic prev_level = 1'b0;

  function automatic bit m_busy();
    return tnow < m_ws + S + G;
  endfunction

  function automatic logic [6:0] exp_vec();
    return {m_busy() && ((tnow - m_ws) < S), m_busy(), 4'(m_pend), m_ovf};
  endfunction

  function automatic logic [6:0] obs_vec();
    return {level_o, busy_o, pending_o, overflow_o};
  endfunction

  task automatic set_in(input logic p, input logic c, input logic r);
    pulse_i = p; clear_i = c; reset = r;
`ifndef PULSE_TO_LEVEL_TX_ACK_EN
    ack_i = 1'($urandom_range(0, 1));
`endif
    @(negedge clk);
  endtask

  task automatic adv();
    bit drop, last;
    if (level_o === 1'b1 && prev_level !== 1'b1) rises++;
    prev_level = level_o;
    if (reset) begin
      accepted -= m_pend;
      m_pend = 0; m_ws = -1000; m_ovf = 1'b0;
    end else begin
      drop = 1'b0;
      last = m_busy() && (tnow == m_ws + S + G - 1);
      if (!m_busy() || last) begin
        if (m_pend + int'(pulse_i) > 0) begin
          accepted += int'(pulse_i);
          m_pend = m_pend + int'(pulse_i) - 1;
          m_ws = tnow + 1;
        end
      end else if (pulse_i) begin
        if (m_pend < PMAX) begin m_pend++; accepted++; end
        else drop = 1'b1;
      end
      m_ovf = drop ? 1'b1 : (clear_i ? 1'b0 : m_ovf);
    end
    tnow++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    set_in(1'b1, 1'b0, 1'b1); adv();
    for (int i = 0; i < 4; i++) begin
      set_in(1'($urandom_range(0, 1)), 1'b0, 1'b1);
      total++; if (obs_vec() !== 7'b0) begin bad++; $display("FAIL reset_state t=%0d got=%b exp=%b", tnow, obs_vec(), 7'b0); end
      adv();
    end
    for (int i = 0; i < 3; i++) begin
      set_in(i == 0, 1'b0, 1'b0);
      total++; if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL reset_release t=%0d got=%b exp=%b", tnow, obs_vec(), exp_vec()); end
      adv();
    end
    total++; if (level_o !== 1'b1) begin bad++; $display("FAIL first_pulse_after_reset got=%b exp=1", level_o); end
    for (int i = 0; i < 12; i++) begin set_in(0, 0, 0); adv(); end
  endtask

  task automatic test_single();
    int highs = 0;
    for (int i = 0; i < 14; i++) begin
      set_in(i == 2, 1'b0, 1'b0);
      total++; if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL single t=%0d got=%b exp=%b", tnow, obs_vec(), exp_vec()); end
      if (level_o === 1'b1) highs++;
      adv();
    end
    total++; if (highs != S) begin bad++; $display("FAIL single_width got=%0d exp=%0d", highs, S); end
  endtask

  task automatic test_three();
    int peak = 0;
    for (int i = 0; i < 30; i++) begin
      set_in(i == 0 || i == 2 || i == 3, 1'b0, 1'b0);
      total++; if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL three t=%0d got=%b exp=%b", tnow, obs_vec(), exp_vec()); end
      if (int'(pending_o) > peak) peak = int'(pending_o);
      adv();
    end
    total++; if (peak != 2) begin bad++; $display("FAIL three_peak got=%0d exp=2", peak); end
  endtask

  task automatic test_saturate();
    int peak = 0;
    for (int i = 0; i < 160; i++) begin
      set_in(i < 20, i == 24, 1'b0);
      total++; if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL saturate t=%0d got=%b exp=%b", tnow, obs_vec(), exp_vec()); end
      if (int'(pending_o) > peak) peak = int'(pending_o);
      if (i == 22) begin
        total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL overflow_set got=%b exp=1", overflow_o); end
      end
      if (i == 26) begin
        total++; if (overflow_o !== 1'b0 || pending_o == '0) begin bad++; $display("FAIL overflow_clear got=%b/%0d exp=0/nonzero", overflow_o, pending_o); end
      end
      adv();
    end
    total++; if (peak != PMAX) begin bad++; $display("FAIL saturate_peak got=%0d exp=%0d", peak, PMAX); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) begin
      set_in(i < 4, 1'b0, i == 4);
      if (i == 4) begin
        total++; if (pending_o !== 4'd3 || level_o !== 1'b1) begin bad++; $display("FAIL reset_mid_pre got=%0d/%b exp=3/1", pending_o, level_o); end
      end
      total++; if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL reset_mid t=%0d got=%b exp=%b", tnow, obs_vec(), exp_vec()); end
      adv();
    end
  endtask

  task automatic test_boundary();
    for (int i = 0; i < 24; i++) begin
      set_in(i == 0 || i == 1 || i == 8, 1'b0, 1'b0);
      if (i == 9) begin
        total++; if (pending_o !== 4'd1 || level_o !== 1'b1) begin bad++; $display("FAIL boundary_restart got=%0d/%b exp=1/1", pending_o, level_o); end
      end
      total++; if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL boundary t=%0d got=%b exp=%b", tnow, obs_vec(), exp_vec()); end
      adv();
    end
  endtask

  task automatic test_back_to_back();
    int idle_gaps = 0;
    for (int i = 0; i < 20; i++) begin
      set_in(i == 0 || i == 8, 1'b0, 1'b0);
      total++; if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL back_to_back t=%0d got=%b exp=%b", tnow, obs_vec(), exp_vec()); end
      if (i >= 1 && i <= 16 && busy_o !== 1'b1) idle_gaps++;
      adv();
    end
    total++; if (idle_gaps != 0) begin bad++; $display("FAIL back_to_back_gap got=%0d exp=0", idle_gaps); end
  endtask

  task automatic test_random();
    logic p;
    for (int i = 0; i < 1500; i++) begin
      p = ((i / 40) % 2 == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
      set_in(p, $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0);
      total++; if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL random t=%0d got=%b exp=%b", tnow, obs_vec(), exp_vec()); end
      adv();
    end
    for (int i = 0; i < 150; i++) begin
      set_in(0, 0, 0);
      total++; if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL drain t=%0d got=%b exp=%b", tnow, obs_vec(), exp_vec()); end
      adv();
    end
    total++; if (rises != accepted) begin bad++; $display("FAIL event_count got=%0d rises exp=%0d", rises, accepted); end
  endtask

  task automatic test_ack();
    logic exp_l;
    reset = 1'b1; pulse_i = 1'b0; clear_i = 1'b0; ack_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int t = 0; t < 18; t++) begin
      pulse_i = (t <= 1);
      ack_i = (t >= 8 && t <= 14);
      @(negedge clk);
      exp_l = (t >= 1 && t <= 8) || (t >= 16);
      total++; if (level_o !== exp_l) begin bad++; $display("FAIL ack_level t=%0d got=%b exp=%b", t, level_o, exp_l); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
`ifdef PULSE_TO_LEVEL_TX_ACK_EN
    test_ack();
`else
    test_reset();
    test_single();
    test_three();
    test_saturate();
    test_reset_mid();
    test_boundary();
    test_back_to_back();
    test_random();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
